// File: rtl/hilo_pkg.sv
// Shared types and constants for the HI/LO write pipeline.
// One record describes the HI/LO write carried by a single pipeline stage.
package hilo_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned HILO_W = 2 * DATA_W;

    typedef struct packed {
        logic              we_hi;
        logic              we_lo;
        logic [DATA_W-1:0] hi;
        logic [DATA_W-1:0] lo;
    } hilo_rec_t;

    localparam hilo_rec_t HILO_REC_NULL = '{we_hi: 1'b0, we_lo: 1'b0, hi: '0, lo: '0};

    function automatic logic rec_pending(input hilo_rec_t rec);
        return rec.we_hi | rec.we_lo;
    endfunction

endpackage

// File: rtl/hilo_pipe_if.sv
// Issue/commit bundle between the E-stage issue logic and the HI/LO write pipeline.
interface hilo_pipe_if #(
    parameter int unsigned NUM_SLOTS  = 2,
    parameter int unsigned PIPE_DEPTH = 2
);
    import hilo_pkg::*;

    logic                          i_stall;
    logic [PIPE_DEPTH-1:0]         i_flush;
    logic [NUM_SLOTS-1:0]          i_wr_hi;
    logic [NUM_SLOTS-1:0]          i_wr_lo;
    logic [NUM_SLOTS*HILO_W-1:0]   i_wdata;
    logic [HILO_W-1:0]             o_hilo;
    logic [HILO_W-1:0]             o_hilo_arch;
    logic                          o_pending;

    modport master (
        output i_stall, i_flush, i_wr_hi, i_wr_lo, i_wdata,
        input  o_hilo, o_hilo_arch, o_pending
    );

    modport slave (
        input  i_stall, i_flush, i_wr_hi, i_wr_lo, i_wdata,
        output o_hilo, o_hilo_arch, o_pending
    );

endinterface

// File: rtl/hilo_slot_merge.sv
// Merges per-slot HI/LO writes of one issue bundle into a single record.
// Each half is taken from the youngest (highest-index) slot that writes it.
module hilo_slot_merge
    import hilo_pkg::*;
#(
    parameter int unsigned NUM_SLOTS = 2
) (
    input  logic [NUM_SLOTS-1:0]        wr_hi,
    input  logic [NUM_SLOTS-1:0]        wr_lo,
    input  logic [NUM_SLOTS*HILO_W-1:0] wdata,
    output hilo_rec_t                   rec_c
);

    always_comb begin
        rec_c = HILO_REC_NULL;
        // Ascending scan so the youngest enabling slot wins.
        for (int unsigned s = 0; s < NUM_SLOTS; s++) begin
            if (wr_hi[s]) begin
                rec_c.we_hi = 1'b1;
                rec_c.hi    = wdata[s*HILO_W+DATA_W +: DATA_W];
            end
            if (wr_lo[s]) begin
                rec_c.we_lo = 1'b1;
                rec_c.lo    = wdata[s*HILO_W +: DATA_W];
            end
        end
    end

endmodule

// File: rtl/hilo_pipe.sv
// HI/LO architectural register fed by a PIPE_DEPTH-stage write pipeline with
// stall, per-stage flush, commit at the last stage and per-half forwarding.
module hilo_pipe
    import hilo_pkg::*;
#(
    parameter int unsigned NUM_SLOTS  = 2,
    parameter int unsigned PIPE_DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst,
    hilo_pipe_if.slave bus
);

    localparam int unsigned LAST = PIPE_DEPTH - 1;

    hilo_rec_t         merged_c;
    hilo_rec_t         stage_q [PIPE_DEPTH];
    hilo_rec_t         stage_d [PIPE_DEPTH];
    logic [HILO_W-1:0] arch_q;
    logic [HILO_W-1:0] arch_d;
    logic              flush_any;
    int unsigned       flush_top;
    logic              commit_c;
    logic [DATA_W-1:0] fwd_hi;
    logic [DATA_W-1:0] fwd_lo;
    logic              pending_c;

    hilo_slot_merge #(.NUM_SLOTS(NUM_SLOTS)) u_merge (
        .wr_hi (bus.i_wr_hi),
        .wr_lo (bus.i_wr_lo),
        .wdata (bus.i_wdata),
        .rec_c (merged_c)
    );

    // Oldest flushed stage bounds the kill region.
    always_comb begin
        flush_any = |bus.i_flush;
        flush_top = 0;
        for (int unsigned k = 0; k < PIPE_DEPTH; k++) begin
            if (bus.i_flush[k]) flush_top = k;
        end
    end

    always_comb begin
        for (int unsigned k = 0; k < PIPE_DEPTH; k++) begin
            stage_d[k] = stage_q[k];
        end
        if (flush_any) begin
            stage_d[0] = HILO_REC_NULL;
            for (int unsigned k = 1; k < PIPE_DEPTH; k++) begin
                if (k <= flush_top) begin
                    stage_d[k] = HILO_REC_NULL;
                end else if (!bus.i_stall) begin
                    // The stage right behind the kill region receives a bubble.
                    stage_d[k] = (k == flush_top + 1) ? HILO_REC_NULL : stage_q[k-1];
                end
            end
        end else if (!bus.i_stall) begin
            stage_d[0] = merged_c;
            for (int unsigned k = 1; k < PIPE_DEPTH; k++) begin
                stage_d[k] = stage_q[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < PIPE_DEPTH; k++) begin
                stage_q[k] <= HILO_REC_NULL;
            end
        end else begin
            stage_q <= stage_d;
        end
    end

    always_comb begin
        commit_c = !bus.i_stall && !(flush_any && (flush_top == LAST));
        arch_d   = arch_q;
        if (commit_c && stage_q[LAST].we_hi) arch_d[HILO_W-1 -: DATA_W] = stage_q[LAST].hi;
        if (commit_c && stage_q[LAST].we_lo) arch_d[DATA_W-1:0]         = stage_q[LAST].lo;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            arch_q <= '0;
        end else begin
            arch_q <= arch_d;
        end
    end

    // Youngest in-flight write of each half overrides the committed value.
    always_comb begin
        fwd_hi    = arch_q[HILO_W-1 -: DATA_W];
        fwd_lo    = arch_q[DATA_W-1:0];
        pending_c = 1'b0;
        for (int k = int'(PIPE_DEPTH) - 1; k >= 0; k--) begin
            if (stage_q[k].we_hi) fwd_hi = stage_q[k].hi;
            if (stage_q[k].we_lo) fwd_lo = stage_q[k].lo;
            pending_c = pending_c | rec_pending(stage_q[k]);
        end
    end

    assign bus.o_hilo      = {fwd_hi, fwd_lo};
    assign bus.o_hilo_arch = arch_q;
    assign bus.o_pending   = pending_c;

endmodule

// File: tb/tb_hilo_pipe.sv
// Scoreboard bench for hilo_pipe: a queue-based reference model predicts the
// outputs after each edge; a monitor compares them one cycle at a time.
module tb_hilo_pipe;
    import hilo_pkg::*;

    localparam int unsigned NS = 2;
    localparam int unsigned PD = 2;
    localparam int unsigned WD = NS * HILO_W;

    typedef struct {
        bit          wh;
        bit          wl;
        logic [31:0] h;
        logic [31:0] l;
    } mrec_t;

    typedef struct {
        logic [63:0] hilo;
        logic [63:0] arch;
        logic        pend;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    hilo_pipe_if #(.NUM_SLOTS(NS), .PIPE_DEPTH(PD)) bus ();

    hilo_pipe #(.NUM_SLOTS(NS), .PIPE_DEPTH(PD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    mrec_t       mpipe[$];
    logic [63:0] march;
    exp_t        expq[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;

    function automatic mrec_t null_rec();
        mrec_t r;
        r.wh = 0; r.wl = 0; r.h = '0; r.l = '0;
        return r;
    endfunction

    function automatic logic [WD-1:0] pack(input logic [31:0] h0, input logic [31:0] l0,
                                           input logic [31:0] h1, input logic [31:0] l1);
        return {h1, l1, h0, l0};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: stage list indexed youngest-first; an advance pushes at the
    // front and retires from the back into the architectural value.
    task automatic model(input bit r, input bit st, input logic [PD-1:0] fl,
                         input logic [NS-1:0] wh, input logic [NS-1:0] wl, input logic [WD-1:0] wd);
        exp_t  e;
        mrec_t iss, ret;
        int    f;
        if (r) begin
            foreach (mpipe[k]) mpipe[k] = null_rec();
            march = '0;
        end else begin
            f = -1;
            for (int k = 0; k < int'(PD); k++) if (fl[k]) f = k;
            for (int k = 0; k <= f; k++) mpipe[k] = null_rec();
            if (!st) begin
                iss = null_rec();
                if (f < 0) begin
                    for (int s = int'(NS) - 1; s >= 0; s--)
                        if (wh[s] && !iss.wh) begin iss.wh = 1; iss.h = wd[s*64+32 +: 32]; end
                    for (int s = int'(NS) - 1; s >= 0; s--)
                        if (wl[s] && !iss.wl) begin iss.wl = 1; iss.l = wd[s*64 +: 32]; end
                end
                mpipe.push_front(iss);
                ret = mpipe.pop_back();
                if (ret.wh) march[63:32] = ret.h;
                if (ret.wl) march[31:0]  = ret.l;
            end
        end
        e.arch = march;
        e.hilo = march;
        e.pend = 1'b0;
        for (int k = int'(PD) - 1; k >= 0; k--) begin
            if (mpipe[k].wh) e.hilo[63:32] = mpipe[k].h;
            if (mpipe[k].wl) e.hilo[31:0]  = mpipe[k].l;
            if (mpipe[k].wh || mpipe[k].wl) e.pend = 1'b1;
        end
        expq.push_back(e);
    endtask

    task automatic step(input bit r, input bit st, input logic [PD-1:0] fl,
                        input logic [NS-1:0] wh, input logic [NS-1:0] wl, input logic [WD-1:0] wd);
        @(negedge clk);
        rst         = r;
        bus.i_stall = st;
        bus.i_flush = fl;
        bus.i_wr_hi = wh;
        bus.i_wr_lo = wl;
        bus.i_wdata = wd;
        model(r, st, fl, wh, wl, wd);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, '0, '0, '0, '0);
    endtask

    always @(posedge clk) begin
        #1;
        if (expq.size() != 0) begin
            mon_e = expq.pop_front();
            chk("o_hilo", bus.o_hilo, mon_e.hilo);
            chk("o_hilo_arch", bus.o_hilo_arch, mon_e.arch);
            chk("o_pending", 64'(bus.o_pending), 64'(mon_e.pend));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WD-1:0] rd;
        for (int k = 0; k < int'(PD); k++) mpipe.push_back(null_rec());
        march       = '0;
        rst         = 1'b1;
        bus.i_stall = 1'b0;
        bus.i_flush = '0;
        bus.i_wr_hi = '0;
        bus.i_wr_lo = '0;
        bus.i_wdata = '0;

        step(1, 0, '0, '0, '0, '0);
        step(1, 0, '0, '0, '0, '0);
        // Basic write through both halves.
        step(0, 0, '0, 2'b01, 2'b01, pack(32'd1, 32'd2, 0, 0));
        idle(3);
        // Intra-bundle merge followed by an MTLO.
        step(0, 0, '0, 2'b11, 2'b10, pack(32'hA, 0, 32'hB, 32'hC));
        step(0, 0, '0, 2'b00, 2'b01, pack(0, 32'hD, 0, 0));
        idle(3);
        // Back-to-back HI writes forward the younger.
        step(1, 0, '0, '0, '0, '0);
        step(0, 0, '0, 2'b01, 2'b00, pack(32'h1111, 0, 0, 0));
        step(0, 0, '0, 2'b10, 2'b00, pack(0, 0, 32'h2222, 0));
        idle(3);
        // Stall with a record in the last stage; issues during stall dropped.
        step(0, 0, '0, 2'b01, 2'b01, pack(32'h55, 32'h66, 0, 0));
        idle(1);
        for (int i = 0; i < 3; i++) step(0, 1, '0, 2'b11, 2'b11, pack(32'hEE, 32'hEE, 32'hFF, 32'hFF));
        idle(3);
        // Flush both stages under stall.
        step(0, 0, '0, 2'b01, 2'b01, pack(32'h77, 32'h78, 0, 0));
        step(0, 0, '0, 2'b10, 2'b10, pack(0, 0, 32'h79, 32'h7A));
        step(0, 1, 2'b10, 2'b01, 2'b01, pack(32'h7B, 32'h7C, 0, 0));
        idle(2);
        // Flush only M; W still commits. Then reset mid-pipe.
        step(0, 0, '0, 2'b01, 2'b00, pack(32'h88, 0, 0, 0));
        step(0, 0, '0, 2'b00, 2'b01, pack(0, 32'h99, 0, 0));
        step(0, 0, 2'b01, 2'b01, 2'b01, pack(32'h9A, 32'h9B, 0, 0));
        idle(2);
        step(0, 0, '0, 2'b11, 2'b11, pack(32'h1, 32'h2, 32'h3, 32'h4));
        step(0, 0, '0, 2'b01, 2'b01, pack(32'h5, 32'h6, 0, 0));
        step(1, 0, '0, '0, '0, '0);
        idle(2);
        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            rd = {$urandom, $urandom, $urandom, $urandom};
            step(($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 99) < 20),
                 ($urandom_range(0, 99) < 12) ? PD'($urandom_range(1, (1 << PD) - 1)) : '0,
                 NS'($urandom), NS'($urandom), rd);
        end
        idle(3);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations expected 0", expq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
